// File: rtl/dtfm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dtfm_pkg : shared frame-format constants and header-word builder for     |
// |            the dCLK/dFM/dDAT telemetry link (DTFM receiver, dtfm_tx).     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package dtfm_pkg;

    localparam int BITS_PER_WORD = 16;
    localparam int WORDS_PER_STR = 10;
    localparam int STRS_PER_FRM  = 64;

    localparam int BIT_W = 4;
    localparam int WRD_W = 5;
    localparam int STR_W = 6;
    localparam int FRM_W = 9;

    // Header layout: frame number, string number, and a flag that is 1 for
    // the even (first) string of a pair.
    function automatic logic [BITS_PER_WORD-1:0] hdr_word(
        input logic [FRM_W-1:0] frm,
        input logic [STR_W-1:0] str,
        input logic             first
    );
        return {frm, str, first};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dtfm_tx_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dtfm_tx_if : link outputs and payload read port of dtfm_tx.              |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
interface dtfm_tx_if;
    import dtfm_pkg::*;

    logic                     en;
    logic                     rd_req;
    logic [WRD_W-1:0]         rd_addr;
    logic [STR_W-1:0]         rd_str;
    logic [BITS_PER_WORD-1:0] rd_data;
    logic                     dCLK;
    logic                     dFM;
    logic                     dDAT;
    logic                     frm_done;

    modport master (
        input  en, rd_data,
        output rd_req, rd_addr, rd_str, dCLK, dFM, dDAT, frm_done
    );

    modport slave (
        output en, rd_data,
        input  rd_req, rd_addr, rd_str, dCLK, dFM, dDAT, frm_done
    );
endinterface
`default_nettype wire

// File: rtl/dtfm_bitclk.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dtfm_bitclk : DIV divider making the 50 % duty bit clock and one-clk     |
// |               bit_start / bit_mid strobes.                               |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module dtfm_bitclk #(
    parameter int DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_run,
    input  logic i_stop,
    output logic o_dclk,
    output logic o_bit_start,
    output logic o_bit_mid
);

    localparam logic [8:0] c_MID  = 9'(DIV);
    localparam logic [8:0] c_LAST = 9'(2 * DIV - 1);

    logic [8:0] r_ph;
    logic       r_dclk;

    assign o_bit_start = i_run && (r_ph == 9'd0);
    assign o_bit_mid   = i_run && (r_ph == c_MID);
    assign o_dclk      = r_dclk;

    // Phase restarts at 0 whenever the transmitter is idle, so the first
    // rise lands on the clk right after the run begins.
    always_ff @(posedge clk) begin
        if (!rst_n || !i_run) begin
            r_ph   <= 9'd0;
            r_dclk <= 1'b0;
        end else begin
            r_ph <= (r_ph == c_LAST) ? 9'd0 : r_ph + 9'd1;
            if (i_stop)
                r_dclk <= 1'b0;
            else if (o_bit_start)
                r_dclk <= 1'b1;
            else if (o_bit_mid)
                r_dclk <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dtfm_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dtfm_tx : telemetry frame transmitter; builds headers, fetches payload   |
// |           words and shifts them out MSB first with dCLK and dFM.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dtfm_tx
    import dtfm_pkg::*;
#(
    parameter int DIV = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    dtfm_tx_if.master bus
);

    localparam logic [0:0]       c_IDLE     = 1'b0;
    localparam logic [0:0]       c_RUN      = 1'b1;
    localparam logic [BIT_W-1:0] c_LAST_BIT = BIT_W'(BITS_PER_WORD - 1);
    localparam logic [WRD_W-1:0] c_HDR_ODD  = WRD_W'(WORDS_PER_STR);
    localparam logic [WRD_W-1:0] c_END_EVEN = WRD_W'(WORDS_PER_STR - 1);
    localparam logic [WRD_W-1:0] c_END_PAIR = WRD_W'(2 * WORDS_PER_STR - 1);
    localparam logic [STR_W-1:0] c_LAST_STR = STR_W'(STRS_PER_FRM - 1);

    logic [0:0]               r_state;
    logic [0:0]               w_state_nxt;
    logic                     w_run, w_bnd, w_stop;
    logic                     w_bit_start, w_bit_mid, w_dclk;
    logic [BIT_W-1:0]         r_bcnt;
    logic [WRD_W-1:0]         r_wrd;
    logic [STR_W-1:0]         r_str;
    logic [FRM_W-1:0]         r_frm;
    logic                     r_sent, r_eof;
    logic [BITS_PER_WORD-1:0] r_sh, r_hold, w_word;
    logic                     r_req, r_req_d1, r_req_d2;
    logic [WRD_W-1:0]         r_addr;
    logic [STR_W-1:0]         r_rstr;
    logic                     r_dfm, r_ddat, r_done;
    logic                     w_pos_zero;

    dtfm_bitclk #(.DIV(DIV)) u_bitclk (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_run       (w_run),
        .i_stop      (w_stop),
        .o_dclk      (w_dclk),
        .o_bit_start (w_bit_start),
        .o_bit_mid   (w_bit_mid)
    );

    assign w_run      = (r_state == c_RUN);
    assign w_pos_zero = (r_bcnt == '0) && (r_wrd == '0) && (r_str == '0);
    assign w_bnd      = w_run && w_bit_start && r_eof;
    assign w_stop     = w_bnd && !bus.en;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= c_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (bus.en) w_state_nxt = c_RUN;
            c_RUN:   if (w_stop) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_word = r_hold;
        if (r_wrd == '0)
            w_word = hdr_word(r_frm, r_str, 1'b1);
        else if (r_wrd == c_HDR_ODD)
            w_word = hdr_word(r_frm, r_str, 1'b0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bcnt   <= '0;
            r_wrd    <= '0;
            r_str    <= '0;
            r_frm    <= '0;
            r_sent   <= 1'b0;
            r_eof    <= 1'b0;
            r_sh     <= '0;
            r_hold   <= '0;
            r_req    <= 1'b0;
            r_req_d1 <= 1'b0;
            r_req_d2 <= 1'b0;
            r_addr   <= '0;
            r_rstr   <= '0;
            r_dfm    <= 1'b0;
            r_ddat   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done   <= w_bnd;
            r_req    <= 1'b0;
            r_req_d1 <= r_req;
            r_req_d2 <= r_req_d1;
            if (r_req_d2)
                r_hold <= bus.rd_data;

            if (!w_run) begin
                r_bcnt <= '0;
                r_wrd  <= '0;
                r_str  <= '0;
                r_sent <= 1'b0;
                r_eof  <= 1'b0;
                r_addr <= '0;
                r_rstr <= '0;
                r_dfm  <= 1'b0;
                r_ddat <= 1'b0;
            end else if (w_stop) begin
                r_sent <= 1'b0;
                r_eof  <= 1'b0;
                r_dfm  <= 1'b0;
                r_ddat <= 1'b0;
            end else if (w_bit_start) begin
                r_sent <= 1'b1;
                r_eof  <= 1'b0;
                r_dfm  <= w_pos_zero;
                if (r_bcnt == '0) begin
                    r_ddat <= w_word[BITS_PER_WORD-1];
                    r_sh   <= {w_word[BITS_PER_WORD-2:0], 1'b0};
                    // Fetch the following word a whole word period ahead.
                    if (r_wrd != c_END_EVEN && r_wrd != c_END_PAIR) begin
                        r_req  <= 1'b1;
                        r_addr <= r_wrd + 5'd1;
                        r_rstr <= r_str;
                    end
                end else begin
                    r_ddat <= r_sh[BITS_PER_WORD-1];
                    r_sh   <= {r_sh[BITS_PER_WORD-2:0], 1'b0};
                end
                if (r_bcnt == c_LAST_BIT) begin
                    r_bcnt <= '0;
                    r_wrd  <= (r_wrd == c_END_PAIR) ? '0 : r_wrd + 5'd1;
                    if (r_wrd == c_END_EVEN || r_wrd == c_END_PAIR)
                        r_str <= r_str + 6'd1;
                    if (r_wrd == c_END_PAIR && r_str == c_LAST_STR)
                        r_frm <= r_frm + 9'd1;
                end else begin
                    r_bcnt <= r_bcnt + 4'd1;
                end
            end else if (w_bit_mid) begin
                // Position has already wrapped once the final bit is on the wire.
                r_eof <= r_sent && w_pos_zero;
            end
        end
    end

    assign bus.rd_req   = r_req;
    assign bus.rd_addr  = r_addr;
    assign bus.rd_str   = r_rstr;
    assign bus.dCLK     = w_dclk;
    assign bus.dFM      = r_dfm;
    assign bus.dDAT     = r_ddat;
    assign bus.frm_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dtfm_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dtfm_tx : directed bench; DIV=16 instance for start-up timing, DIV=2  |
// |              instance decoded by a receiver model over full frames.      |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_dtfm_tx;

    logic clk   = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    int   cyc   = 0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dtfm_tx_if ifa ();
    dtfm_tx_if ifb ();

    dtfm_tx #(.DIV(2))  u_dut_a (.clk(clk), .rst_n(rst_a), .bus(ifa));
    dtfm_tx #(.DIV(16)) u_dut_b (.clk(clk), .rst_n(rst_b), .bus(ifb));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Payload source for A: {str, addr, 5'd0} two clk after the strobe.
    logic        a_p1 = 1'b0, a_p2 = 1'b0;
    logic [15:0] a_p1d = '0, a_p2d = '0;
    always @(posedge clk) begin
        a_p1  <= ifa.rd_req;
        a_p1d <= {ifa.rd_str, ifa.rd_addr, 5'd0};
        a_p2  <= a_p1;
        a_p2d <= a_p1d;
    end
    assign ifa.rd_data = a_p2 ? a_p2d : 16'hDEAD;
    assign ifb.rd_data = 16'hA5C3;

    // Receiver model for A: resyncs on dFM, checks every decoded word.
    logic        a_prev = 1'b0;
    logic [15:0] a_sh = '0, a_last_hdr0 = '0, a_hdr63 = '0;
    bit          a_valid = 1'b0, a_rise_seen = 1'b0;
    int          a_pos = 0, a_frames = 0, a_cur = 0, a_words = 0, a_hdr0_n = 0;
    int          a_req_cnt = 0, a_bad = 0, a_done_cnt = 0, a_done_cyc = 0, a_rise_cyc = 0;

    always @(negedge clk) begin : p_rx_a
        int wi, s, w, slot;
        logic [15:0] e;
        if (ifa.frm_done) begin
            a_done_cnt++;
            a_done_cyc = cyc;
        end
        if (ifa.rd_req) begin
            a_req_cnt++;
            if (ifa.rd_addr == 5'd0 || ifa.rd_addr == 5'd10 || ifa.rd_addr > 5'd19)
                a_bad++;
        end
        if (ifa.dCLK && !a_prev && !a_rise_seen) begin
            a_rise_seen = 1'b1;
            a_rise_cyc  = cyc;
        end
        if (!ifa.dCLK && a_prev) begin
            a_sh = {a_sh[14:0], ifa.dDAT};
            if (ifa.dFM) begin
                a_pos   = 0;
                a_valid = 1'b1;
                a_cur   = a_frames;
                a_frames++;
            end else begin
                a_pos++;
            end
            if (a_valid && (a_pos % 16) == 15) begin
                wi   = a_pos / 16;
                s    = wi / 10;
                w    = wi % 10;
                slot = (s % 2 == 1) ? w + 10 : w;
                if (w == 0) begin
                    e = {a_cur[8:0], s[5:0], ~s[0]};
                    if (wi == 0) begin
                        a_last_hdr0 = a_sh;
                        a_hdr0_n++;
                    end
                    if (wi == 630) a_hdr63 = a_sh;
                    chk("hdr_word", a_sh, e);
                end else begin
                    e = {s[5:0], slot[4:0], 5'd0};
                    chk("payload_word", a_sh, e);
                end
                a_words++;
            end
        end
        a_prev = ifa.dCLK;
    end

    // Receiver model for B: first three words and first two fetch strobes.
    logic        b_prev = 1'b0;
    logic [15:0] b_sh = '0;
    logic [15:0] b_w [3];
    logic [4:0]  b_addr0 = '0;
    int          b_nb = 0, b_nw = 0, b_req_n = 0;
    int          b_req_cyc [2];

    always @(negedge clk) begin : p_rx_b
        if (ifb.rd_req) begin
            if (b_req_n < 2) b_req_cyc[b_req_n] = cyc;
            if (b_req_n == 0) b_addr0 = ifb.rd_addr;
            b_req_n++;
        end
        if (!ifb.dCLK && b_prev) begin
            b_sh = {b_sh[14:0], ifb.dDAT};
            b_nb++;
            if ((b_nb % 16) == 0 && b_nw < 3) begin
                b_w[b_nw] = b_sh;
                b_nw++;
            end
        end
        b_prev = ifb.dCLK;
    end

    initial begin
        int cnt_fm, cnt_ck, hi, lo, n0;
        ifa.en = 1'b0;
        ifb.en = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs_a", {ifa.rd_req, ifa.rd_addr, ifa.rd_str, ifa.dCLK, ifa.dFM, ifa.dDAT, ifa.frm_done}, 0);
        chk("reset_outs_b", {ifb.rd_req, ifb.rd_addr, ifb.rd_str, ifb.dCLK, ifb.dFM, ifb.dDAT, ifb.frm_done}, 0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(negedge clk);
        chk("idle_outs_b", {ifb.dCLK, ifb.dFM, ifb.dDAT, ifb.rd_req}, 0);

        // DIV=16: start latency, marker width, first words, fetch spacing.
        ifb.en = 1'b1;
        @(negedge clk);
        chk("start_dclk_early", ifb.dCLK, 0);
        @(negedge clk);
        chk("start_dclk", ifb.dCLK, 1);
        chk("start_dfm", ifb.dFM, 1);
        chk("start_ddat", ifb.dDAT, 0);
        cnt_fm = 0;
        cnt_ck = 0;
        for (int i = 0; i < 100 && ifb.dFM; i++) begin
            cnt_fm++;
            if (ifb.dCLK) cnt_ck++;
            @(negedge clk);
        end
        chk("dfm_width_div16", cnt_fm, 32);
        chk("dclk_high_div16", cnt_ck, 16);
        for (int i = 0; i < 2000 && b_nw < 3; i++) @(negedge clk);
        chk("b_words_wait", b_nw >= 3, 1);
        chk("b_word0_hdr", b_w[0], 16'h0001);
        chk("b_word1", b_w[1], 16'hA5C3);
        chk("b_word2", b_w[2], 16'hA5C3);
        chk("b_req_addr0", b_addr0, 5'd1);
        chk("b_req_spacing", b_req_cyc[1] - b_req_cyc[0], 512);
        rst_b = 1'b0;

        // DIV=2: duty, full frame decode with en dropped mid-frame.
        ifa.en = 1'b1;
        for (int i = 0; i < 10 && !ifa.dCLK; i++) @(negedge clk);
        hi = 0;
        lo = 0;
        for (int i = 0; i < 20 && ifa.dCLK; i++) begin hi++; @(negedge clk); end
        for (int i = 0; i < 20 && !ifa.dCLK; i++) begin lo++; @(negedge clk); end
        chk("dclk_high_div2", hi, 2);
        chk("dclk_low_div2", lo, 2);
        for (int i = 0; i < 25000 && a_pos < 5000; i++) @(negedge clk);
        chk("a_bit5000_wait", a_pos >= 5000, 1);
        ifa.en = 1'b0;
        for (int i = 0; i < 25000 && a_done_cnt < 1; i++) @(negedge clk);
        chk("a_done_wait", a_done_cnt >= 1, 1);
        repeat (10) @(negedge clk);
        chk("frm_done_count", a_done_cnt, 1);
        chk("frame_length", a_done_cyc - a_rise_cyc, 40960);
        chk("last_bit_pos", a_pos, 10239);
        chk("words_decoded", a_words, 640);
        chk("rd_req_count", a_req_cnt, 576);
        chk("rd_req_bad_slot", a_bad, 0);
        chk("hdr_str63", a_hdr63, 16'h007E);
        chk("idle_outs_a", {ifa.dCLK, ifa.dFM, ifa.dDAT, ifa.rd_req}, 0);

        // Re-enable: frame number continues at 1.
        n0 = a_hdr0_n;
        ifa.en = 1'b1;
        for (int i = 0; i < 300 && a_hdr0_n == n0; i++) @(negedge clk);
        chk("hdr_frame1", a_last_hdr0, 16'h0081);

        // One-clk reset at bit 3000, restart from frame 0.
        for (int i = 0; i < 13000 && a_pos < 3000; i++) @(negedge clk);
        chk("a_bit3000_wait", a_pos >= 3000, 1);
        rst_a    = 1'b0;
        a_valid  = 1'b0;
        a_frames = 0;
        @(negedge clk);
        chk("mid_reset_outs", {ifa.rd_req, ifa.rd_addr, ifa.rd_str, ifa.dCLK, ifa.dFM, ifa.dDAT, ifa.frm_done}, 0);
        rst_a = 1'b1;
        n0 = a_hdr0_n;
        for (int i = 0; i < 300 && a_hdr0_n == n0; i++) @(negedge clk);
        chk("hdr_after_reset", a_last_hdr0, 16'h0001);
        repeat (400) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dtfm_tx.md
# dtfm_tx

Serial telemetry frame transmitter: the sending end of the dCLK/dFM/dDAT link that `DTFM` receives. Generates the bit clock, the one-bit frame marker and MSB-first serial data in the 16-bit-word / 10-word-string / 64-string frame format. Header words are built internally; payload words are fetched from an external buffer through a fixed-latency read port.

## Interface
- `DIV`, 16, clk cycles per dCLK half-period; bit period = 2·DIV clk. Legal range 2..255.
- `clk`  in  1  system clock, 32.768 MHz nominal.
- `rst_n`  in  1  synchronous reset, active-low. Single clock domain.
- `en`  in  1  transmit enable; sampled only at frame boundaries.
- `rd_req`  out  1  one-clk payload read strobe.
- `rd_addr`  out  5  word slot 1..9 or 11..19 within the 20-word string pair.
- `rd_str`  out  6  string number of the requested word.
- `rd_data`  in  16  payload word, valid exactly 2 clk after `rd_req`.
- `dCLK`  out  1  bit clock, 50 % duty.
- `dFM`  out  1  frame marker, high for one bit period.
- `dDAT`  out  1  serial data, MSB first.
- `frm_done`  out  1  one-clk pulse after the last bit of each frame.

## Operation
- Frame: 64 strings × 10 words × 16 bits = 10240 bits. Word counter `wrd` 0..19 spans a string pair; `str` 0..63 increments after words 9 and 19; `frm` (9 bits) increments when `str` wraps 63→0, wraps 511→0.
- Header words, `wrd`=0: {frm[8:0], str[5:0], 1'b1}; `wrd`=10: {frm[8:0], str[5:0], 1'b0}. `str` is even at `wrd`=0 and odd at `wrd`=10.
- All other words come from `rd_data` with `rd_addr`=`wrd`, `rd_str`=`str` of that word.
- States: IDLE → RUN → (frame end) RUN if `en` else IDLE.
  - IDLE: `dCLK`, `dFM`, `dDAT` held 0; counters cleared. `en`=1 starts a frame at the next clk.
  - RUN: continuous bits. `en` is ignored until the last bit of the frame completes; a frame is never truncated.
- `dFM`=1 for exactly the bit period carrying bit 15 of word 0 of string 0; 0 otherwise.
- Payload fetch: `rd_req` fires on the first clk of bit 15's period of the preceding word, so data is always captured before that word's load. The word is latched into a holding register on the 2nd clk after `rd_req` and moved into the shift register at the start of the next word. No back-pressure.
- Reset at any time: on the clk where `rst_n`=0, all outputs, counters and state go to 0/IDLE. The partial frame is discarded and the next frame starts at `frm`=0.

## Timing
- Reset values: `dCLK`=0, `dFM`=0, `dDAT`=0, `rd_req`=0, `rd_addr`=0, `rd_str`=0, `frm_done`=0.
- Bit period: `dCLK` rises on the first clk of the period and falls DIV clk later. `dDAT` and `dFM` change only on the same clk `dCLK` rises, so they are stable across the falling edge, where the receiver samples.
- Start latency: `en` sampled high in IDLE → first `dCLK` rise, with `dFM`=1 and `dDAT`=frame bit 15 of header, on the next clk.
- Frame length: exactly 10240·2·DIV clk. `frm_done` pulses on the clk after the final `dCLK` low half ends, coincident with the next frame's first rise when `en`=1. Frames are back-to-back with no gap.
- `rd_req` spacing: exactly one per payload word, 16·2·DIV clk apart, except across header slots.

## Structure
- Shared package `dtfm_pkg`: BITS_PER_WORD=16, WORDS_PER_STR=10, STRS_PER_FRM=64, frame and word count widths, and a header word build function used by both `DTFM` and `dtfm_tx`.
- Sub-module `dtfm_bitclk`: DIV divider producing `dCLK` plus one-clk `bit_start` and `bit_mid` strobes. The top level holds the FSM, counters, fetch logic and shifter.

## Test plan
- Reset then `en`=1, DIV=16, `rd_data`=16'hA5C3 constant: first `dFM` pulse is 32 clk long. The first 16 bits sampled on `dCLK` fall are 16'h0001. The next word is A5C3. Frame repeats every 327680 clk.
- Full frame decode by the bench model: header of string 63 (`wrd`=10 slot) = {9'd0, 6'd63, 1'b0}. The next frame's first header = {9'd1, 6'd0, 1'b1}. `frm_done` pulses once per frame.
- `rd_data` returns a value equal to {`rd_str`, `rd_addr`, 5'd0} with 2-clk latency: every payload word is received intact. There are 576 `rd_req` per frame, none on `rd_addr` 0 or 10.
- `en` dropped mid-frame at bit 5000: transmission continues to bit 10239. Outputs then go to 0 and state is IDLE. `en` reasserted gives a frame with `frm`=1.
- `rst_n` pulsed low for 1 clk at bit 3000: all outputs are 0 on the next clk. The restart header frame number is 0.
- DIV=2: bit period is 4 clk, `dCLK` has 50 % duty, and fetch timing holds with payload integrity intact.
